riscv_perf_monitor: RTL
=======================

// Module: riscv_perf_monitor
// PURPOSE
//  Run-control and performance monitor that sits beside the RISCVCPU retire stage.
//  Consumes per-instruction retire pulses and decides when the program has ended.
//  Produces the done / clock_count / instr_cnt signals that the top level exports to the matrix-multiply benches.
//  Holds done high after a halt instruction retires and the pipeline drain window expires; CPI = clock_count/instr_cnt.
// PARAMETERS
//  CNT_W        16            width of clock_count and instr_cnt (saturating)
//  HALT_INSTR   32'h0000006F  halt encoding (jal x0,0 self-loop)
//  ECALL_INSTR  32'h00000073  alternate halt encoding (ecall)
//  DRAIN_CYC    4             cycles after halt retire before done, lets in-flight stores commit; range 0..15
//  MAX_CYC      2000          watchdog limit in counted cycles; 0 disables the watchdog
// PORTS
//  CLOCK_50     in   1      system clock, rising edge
//  reset_n      in   1      asynchronous reset, active low
//  start        in   1      level/pulse; leaves IDLE when sampled high
//  retire       in   1      one instruction retired this cycle
//  retire_instr in   32     encoding of the retiring instruction (valid when retire=1)
//  done         out  1      program finished (halt or watchdog); sticky until reset
//  timeout      out  1      done was caused by the watchdog; sticky
//  clock_count  out  CNT_W  cycles spent in RUN+DRAIN
//  instr_cnt    out  CNT_W  instructions retired in RUN, halt instruction included
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; done=0, timeout=0, clock_count=0, instr_cnt=0, drain_ctr=0.
//  FSM states: IDLE, RUN, DRAIN, DONE.
//   IDLE : when start=1, go to RUN next edge; count nothing in IDLE, including a retire in the same cycle as start.
//   RUN  : clock_count+1 every cycle; instr_cnt+1 on every retire.
//          On retire && retire_instr is HALT_INSTR or ECALL_INSTR: count it; drain_ctr<=DRAIN_CYC.
//            Go to DRAIN, or straight to DONE if DRAIN_CYC=0.
//   DRAIN: clock_count+1 per cycle; retires ignored; drain_ctr-1; when drain_ctr==1, go to DONE next edge.
//   DONE : done=1; all counters frozen; start and retire ignored; exit only by reset.
//  Latency: halt retire in cycle T gives done=1 in the cycle after edge T+1+DRAIN_CYC.
//   clock_count is then (cycles in RUN)+DRAIN_CYC.
//  Watchdog: checked in RUN or DRAIN, when MAX_CYC!=0 and clock_count reaches MAX_CYC-1 this cycle.
//   Next state is DONE with timeout=1 and done=1. It takes priority over a simultaneous halt retire.
//   The retire is still counted.
//  Saturation: both counters stop at 2^CNT_W-1 and never wrap. Saturation does not trigger done.
//  done and timeout are registered outputs with no combinational path from inputs.
//   Counters are registered and readable in every state.
//  reset_n asserted mid-run (any state) clears everything immediately; the next run needs start again.
// STRUCTURE
//  Shared package riscv_pkg holds:
//   - state encoding localparams (S_IDLE=2'd0, S_RUN=2'd1, S_DRAIN=2'd2, S_DONE=2'd3)
//   - HALT/ECALL opcode constants, shared with the decoder
//  One sub-module, sat_counter #(W): en, clr, q; holds at all-ones. Instantiate it twice.
//  FSM, drain counter and watchdog compare live in the top module.
// TESTING
//  1 Reset: reset_n=0 mid-RUN with clock_count=37 -> all outputs 0 in the same cycle, state IDLE.
//  2 Basic run: start, then 10 retires over 20 cycles, the 10th being 32'h6F, DRAIN_CYC=4
//    -> done rises 5 edges after the halt; instr_cnt=10; clock_count=20+4.
//  3 Idle gating: retire pulses with start=0 for 8 cycles -> instr_cnt=0, clock_count=0.
//    Then start -> counting begins the next cycle.
//  4 Post-done freeze: after done, 50 cycles of retire=1 with non-halt instructions
//    -> counters unchanged, done stays 1, timeout=0.
//  5 Watchdog: MAX_CYC=2000, no halt -> done=1 and timeout=1 with clock_count=2000.
//    Also a halt on the same cycle as the watchdog -> timeout=1.
//  6 Saturation: CNT_W=4, 20 retires, no halt, watchdog off -> instr_cnt=15 and clock_count=15, done=0.
//    ECALL 32'h73 then ends the run normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V run-control / performance monitor.
//  - FSM state encoding (also visible to anything decoding monitor state)
//  - Halt opcodes shared with the instruction decoder
//  - Helper to recognise an end-of-program instruction
package riscv_pkg;

  // FSM state encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } state_t;

  // jal x0,0 (self-loop) and ecall both mark the end of a program
  localparam logic [31:0] OP_HALT  = 32'h0000_006F;
  localparam logic [31:0] OP_ECALL = 32'h0000_0073;

  // True when instr equals either of the two stop encodings
  function automatic logic is_stop_instr(input logic [31:0] instr,
                                         input logic [31:0] halt_enc,
                                         input logic [31:0] ecall_enc);
    return (instr == halt_enc) || (instr == ecall_enc);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//  clk   in  1  clock, rising edge
//  rst_n in  1  asynchronous reset, active low
//  en    in  1  increment this cycle (ignored once all-ones)
//  clr   in  1  synchronous clear, wins over en
//  q     out W  registered count, holds at all-ones, never wraps
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (en && (q_reg != '1)) begin
      q_reg <= q_reg + W'(1);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/riscv_perf_monitor.sv
// Run-control and performance monitor beside the CPU retire stage.
// Watches retire pulses, counts cycles and instructions for a CPI figure,
// and raises done once a halt/ecall retires and the drain window expires,
// or when the watchdog cycle limit is reached.
//  CLOCK_50     in   1      system clock, rising edge
//  reset_n      in   1      asynchronous reset, active low
//  start        in   1      leaves IDLE when sampled high
//  retire       in   1      one instruction retired this cycle
//  retire_instr in   32     encoding of the retiring instruction
//  done         out  1      program finished; sticky until reset
//  timeout      out  1      done was caused by the watchdog; sticky
//  clock_count  out  CNT_W  cycles spent in RUN+DRAIN (saturating)
//  instr_cnt    out  CNT_W  instructions retired in RUN (saturating)
module riscv_perf_monitor
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter logic [31:0] HALT_INSTR  = OP_HALT,
  parameter logic [31:0] ECALL_INSTR = OP_ECALL,
  parameter int unsigned DRAIN_CYC   = 4,     // 0..15
  parameter int unsigned MAX_CYC     = 2000   // 0 disables the watchdog
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             start,
  input  logic             retire,
  input  logic [31:0]      retire_instr,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] clock_count,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC);

  state_t     state_reg;
  logic [3:0] drain_ctr_reg;
  logic       done_reg;
  logic       timeout_reg;

  logic       counting;
  logic       halt_retire;
  logic       wd_hit;
  logic       cnt_clr;
  logic [1:0] cnt_en;
  logic [CNT_W-1:0] cnt_q [2];

  assign counting    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign halt_retire = retire && is_stop_instr(retire_instr, HALT_INSTR, ECALL_INSTR);

  // Fires on the cycle whose increment lands clock_count on MAX_CYC.
  // A saturated counter narrower than MAX_CYC simply never matches.
  assign wd_hit = (MAX_CYC != 0) && counting &&
                  (32'(clock_count) == (MAX_CYC - 1));

  // Hold the counters at zero while idle so a retire coincident with
  // start is not counted.
  assign cnt_clr   = (state_reg == ST_IDLE);
  assign cnt_en[0] = counting;
  assign cnt_en[1] = (state_reg == ST_RUN) && retire;

  // Slot 0 counts cycles, slot 1 counts retired instructions
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .en    (cnt_en[gi]),
        .clr   (cnt_clr),
        .q     (cnt_q[gi])
      );
    end
  endgenerate

  assign clock_count = cnt_q[0];
  assign instr_cnt   = cnt_q[1];

  // Run-control FSM with registered done/timeout
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      drain_ctr_reg <= 4'd0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) state_reg <= ST_RUN;
        end
        ST_RUN: begin
          // Watchdog wins over a halt retiring in the same cycle
          if (wd_hit) begin
            state_reg   <= ST_DONE;
            done_reg    <= 1'b1;
            timeout_reg <= 1'b1;
          end else if (halt_retire) begin
            drain_ctr_reg <= DRAIN_LOAD;
            if (DRAIN_CYC == 0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          drain_ctr_reg <= drain_ctr_reg - 4'd1;
          if (wd_hit) begin
            state_reg   <= ST_DONE;
            done_reg    <= 1'b1;
            timeout_reg <= 1'b1;
          end else if (drain_ctr_reg == 4'd1) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          // Terminal: only reset leaves this state
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign done    = done_reg;
  assign timeout = timeout_reg;

endmodule
